// File: rtl/graph_mem_responder.sv
// Word-addressed adjacency-matrix store answering 4-phase read handshakes with a fixed latency.
// Optional statistics counters are enabled by defining GRAPH_MEM_STATS_EN.
module graph_mem_responder #(
    parameter int MADDR_WIDTH  = 32,
    parameter int MDATA_WIDTH  = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int ADDR_LSB     = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_read_enable,
    output logic [MDATA_WIDTH-1:0] mem_data,
    output logic                   mem_read_ready,
    output logic                   wait_request,
    input  logic                   host_write_enable,
    input  logic [MADDR_WIDTH-1:0] host_write_addr,
    input  logic [MDATA_WIDTH-1:0] host_write_data,
    output logic                   addr_error
`ifdef GRAPH_MEM_STATS_EN
    ,
    output logic [31:0]            read_count,
    output logic [31:0]            write_count
`endif
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [MADDR_WIDTH-1:0] LSB_MASK  = MADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);
    localparam logic [MADDR_WIDTH-1:0] DEPTH_LIM = MADDR_WIDTH'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND,
        RELEASE
    } state_t;

    state_t                 r_state, w_stateNext;
    logic [CNT_W-1:0]       r_count, w_countNext;
    logic [MADDR_WIDTH-1:0] r_addr, w_addrNext;
    logic [MDATA_WIDTH-1:0] r_data, w_dataNext;
    logic                   r_ready, w_readyNext;
    logic                   r_wait, w_waitNext;
    logic                   r_addrError, w_errorNext;
    logic [MDATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic                   w_readEn;
    logic                   w_readOk;
    logic                   w_writeOk;
    logic [MDATA_WIDTH-1:0] w_readWord;

    function automatic logic addrOk(input logic [MADDR_WIDTH-1:0] a);
        return ((a & LSB_MASK) == '0) && ((a >> ADDR_LSB) < DEPTH_LIM);
    endfunction

    function automatic logic [IDX_W-1:0] wordIndex(input logic [MADDR_WIDTH-1:0] a);
        logic [MADDR_WIDTH-1:0] shifted;
        shifted = a >> ADDR_LSB;
        return shifted[IDX_W-1:0];
    endfunction

    // Anything but a clean 1 (including x/z from an undriven requester) is no request.
    assign w_readEn   = (mem_read_enable === 1'b1);
    assign w_readOk   = addrOk(r_addr);
    assign w_writeOk  = addrOk(host_write_addr);
    assign w_readWord = r_mem[wordIndex(r_addr)];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_wait      <= 1'b0;
            r_addrError <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_count     <= w_countNext;
            r_addr      <= w_addrNext;
            r_data      <= w_dataNext;
            r_ready     <= w_readyNext;
            r_wait      <= w_waitNext;
            r_addrError <= w_errorNext;
        end
    end

    // Counter is loaded with the full latency and the response fires on the edge that
    // finds it at zero, so ready rises READ_LATENCY+1 edges after the accepting edge.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_addrNext  = r_addr;
        w_dataNext  = r_data;
        w_readyNext = r_ready;
        w_waitNext  = r_wait;
        w_errorNext = r_addrError | (host_write_enable && !w_writeOk);
        case (r_state)
            IDLE: begin
                w_waitNext = 1'b0;
                if (w_readEn) begin
                    w_addrNext  = mem_addr;
                    w_countNext = CNT_W'(READ_LATENCY);
                    w_waitNext  = 1'b1;
                    w_stateNext = BUSY;
                end
            end
            BUSY: begin
                w_waitNext = 1'b1;
                if (!w_readEn) begin
                    w_waitNext  = 1'b0;
                    w_stateNext = IDLE;
                end else if (r_count == '0) begin
                    w_readyNext = 1'b1;
                    w_dataNext  = w_readOk ? w_readWord : '0;
                    w_stateNext = RESPOND;
                    if (!w_readOk) begin
                        w_errorNext = 1'b1;
                    end
                end else begin
                    w_countNext = r_count - 1'b1;
                end
            end
            RESPOND: begin
                w_waitNext = 1'b1;
                if (!w_readEn) begin
                    w_readyNext = 1'b0;
                    w_dataNext  = '0;
                    w_stateNext = RELEASE;
                end
            end
            RELEASE: begin
                w_waitNext  = 1'b0;
                w_stateNext = IDLE;
            end
            default: begin
                w_readyNext = 1'b0;
                w_dataNext  = '0;
                w_waitNext  = 1'b0;
                w_stateNext = IDLE;
            end
        endcase
    end

    // Array is not reset; nonblocking write gives read-before-write on a shared edge.
    always_ff @(posedge clock) begin
        if (host_write_enable && w_writeOk) begin
            r_mem[wordIndex(host_write_addr)] <= host_write_data;
        end
    end

`ifdef GRAPH_MEM_STATS_EN
    logic [31:0] r_readCount;
    logic [31:0] r_writeCount;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_readCount  <= '0;
            r_writeCount <= '0;
        end else begin
            if (r_state == BUSY && w_stateNext == RESPOND && r_readCount != 32'hFFFF_FFFF) begin
                r_readCount <= r_readCount + 32'd1;
            end
            if (host_write_enable && w_writeOk && r_writeCount != 32'hFFFF_FFFF) begin
                r_writeCount <= r_writeCount + 32'd1;
            end
        end
    end

    assign read_count  = r_readCount;
    assign write_count = r_writeCount;
`endif

    assign mem_data       = r_data;
    assign mem_read_ready = r_ready;
    assign wait_request   = r_wait;
    assign addr_error     = r_addrError;

endmodule

// File: tb/tb_graph_mem_responder.sv
// Directed bench for graph_mem_responder: latency, row fetch, abort, address errors,
// read/write collision and reset during a response.
module tb_graph_mem_responder;

    logic        clock;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_read_enable;
    logic [31:0] mem_data;
    logic        mem_read_ready;
    logic        wait_request;
    logic        host_write_enable;
    logic [31:0] host_write_addr;
    logic [31:0] host_write_data;
    logic        addr_error;

    int total = 0;
    int bad = 0;
    int readyPulses = 0;
    logic prevReady = 1'b0;

    graph_mem_responder dut (
        .clock            (clock),
        .reset            (reset),
        .mem_addr         (mem_addr),
        .mem_read_enable  (mem_read_enable),
        .mem_data         (mem_data),
        .mem_read_ready   (mem_read_ready),
        .wait_request     (wait_request),
        .host_write_enable(host_write_enable),
        .host_write_addr  (host_write_addr),
        .host_write_data  (host_write_data),
        .addr_error       (addr_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts rising edges of ready to catch duplicate or missing responses.
    always @(negedge clock) begin
        if (mem_read_ready === 1'b1 && prevReady !== 1'b1) begin
            readyPulses = readyPulses + 1;
        end
        prevReady = mem_read_ready;
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected)
        else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                                 input logic en, input logic [31:0] raddr);
        host_write_enable = we;
        host_write_addr   = waddr;
        host_write_data   = wdata;
        mem_read_enable   = en;
        mem_addr          = raddr;
    endtask

    task automatic hostWrite(input logic [31:0] waddr, input logic [31:0] wdata);
        applyStimulus(1'b1, waddr, wdata, 1'b0, 32'h0);
        cycle();
        host_write_enable = 1'b0;
    endtask

    // Full 4-phase read: expects ready exactly 4 edges after the request is presented.
    task automatic doRead(input logic [31:0] raddr, input logic [31:0] expData, input int holdCycles,
                          input string tag);
        int waited;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, raddr);
        waited = 0;
        do begin
            cycle();
            waited++;
            if (waited == 1) checkOutput({tag, "_waitBusy"}, {31'd0, wait_request}, 32'd1);
        end while (mem_read_ready !== 1'b1 && waited < 20);
        checkOutput({tag, "_ready"}, {31'd0, mem_read_ready}, 32'd1);
        checkOutput({tag, "_latency"}, waited, 32'd4);
        checkOutput({tag, "_data"}, mem_data, expData);
        for (int i = 0; i < holdCycles; i++) begin
            mem_addr = 32'h0000_0004;
            cycle();
            checkOutput({tag, "_holdReady"}, {31'd0, mem_read_ready}, 32'd1);
            checkOutput({tag, "_holdData"}, mem_data, expData);
            checkOutput({tag, "_holdWait"}, {31'd0, wait_request}, 32'd1);
        end
        mem_read_enable = 1'b0;
        cycle();
        checkOutput({tag, "_dropReady"}, {31'd0, mem_read_ready}, 32'd0);
        checkOutput({tag, "_dropData"}, mem_data, 32'd0);
        checkOutput({tag, "_releaseWait"}, {31'd0, wait_request}, 32'd1);
        cycle();
        checkOutput({tag, "_idleWait"}, {31'd0, wait_request}, 32'd0);
    endtask

    initial begin
        int startPulses;
        int waited;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (3) cycle();
        checkOutput("rst_ready", {31'd0, mem_read_ready}, 32'd0);
        checkOutput("rst_data", mem_data, 32'd0);
        checkOutput("rst_wait", {31'd0, wait_request}, 32'd0);
        checkOutput("rst_err", {31'd0, addr_error}, 32'd0);
        reset = 1'b0;
        cycle();

        $display("[TB] basic read with latency");
        hostWrite(32'h10, 32'h0000_0007);
        doRead(32'h10, 32'h7, 1, "basic");

        $display("[TB] back-to-back row fetch");
        hostWrite(32'h0, 32'd1);
        hostWrite(32'h4, 32'd2);
        hostWrite(32'h8, 32'd3);
        hostWrite(32'hC, 32'd4);
        startPulses = readyPulses;
        doRead(32'h0, 32'd1, 3, "row0");
        doRead(32'h4, 32'd2, 3, "row1");
        doRead(32'h8, 32'd3, 3, "row2");
        doRead(32'hC, 32'd4, 3, "row3");
        checkOutput("row_pulses", readyPulses - startPulses, 32'd4);
        checkOutput("row_noErr", {31'd0, addr_error}, 32'd0);

        $display("[TB] abort during busy");
        startPulses = readyPulses;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h4);
        cycle();
        mem_read_enable = 1'b0;
        cycle();
        checkOutput("abort_wait", {31'd0, wait_request}, 32'd0);
        repeat (4) cycle();
        checkOutput("abort_ready", {31'd0, mem_read_ready}, 32'd0);
        checkOutput("abort_pulses", readyPulses - startPulses, 32'd0);
        doRead(32'h4, 32'd2, 0, "afterAbort");

        $display("[TB] address errors");
        doRead(32'h2, 32'd0, 0, "misaligned");
        checkOutput("misaligned_err", {31'd0, addr_error}, 32'd1);
        doRead(32'h1000, 32'd0, 0, "outOfRange");
        checkOutput("outOfRange_err", {31'd0, addr_error}, 32'd1);
        hostWrite(32'h1000, 32'hDEAD_BEEF);
        cycle();
        doRead(32'h0, 32'd1, 0, "noAlias");
        checkOutput("errSticky", {31'd0, addr_error}, 32'd1);

        $display("[TB] read/write collision");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h8);
        repeat (3) cycle();
        checkOutput("coll_notYet", {31'd0, mem_read_ready}, 32'd0);
        applyStimulus(1'b1, 32'h8, 32'h9, 1'b1, 32'h8);
        cycle();
        host_write_enable = 1'b0;
        checkOutput("coll_ready", {31'd0, mem_read_ready}, 32'd1);
        checkOutput("coll_data", mem_data, 32'd3);
        mem_read_enable = 1'b0;
        repeat (2) cycle();
        doRead(32'h8, 32'd9, 0, "afterColl");

        $display("[TB] reset during respond");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h8);
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (mem_read_ready !== 1'b1 && waited < 20);
        checkOutput("midRst_ready", {31'd0, mem_read_ready}, 32'd1);
        reset = 1'b1;
        cycle();
        checkOutput("midRst_readyLow", {31'd0, mem_read_ready}, 32'd0);
        checkOutput("midRst_dataLow", mem_data, 32'd0);
        checkOutput("midRst_waitLow", {31'd0, wait_request}, 32'd0);
        checkOutput("midRst_errClear", {31'd0, addr_error}, 32'd0);
        reset = 1'b0;
        mem_read_enable = 1'b0;
        cycle();
        doRead(32'h8, 32'd9, 0, "afterRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
